// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequencer for the iterative multiply/divide unit.
// Captures a mult/div instruction from EX, stalls the front of the pipeline
// while the unit runs, and delivers either a register writeback or a
// status-register write when the operation excepts or times out.
module multdiv_ctrl #(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int MAX_CYCLES = 40,
  parameter int STATUS_MUL = 4,
  parameter int STATUS_DIV = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_is_div,
  input  logic [DATA_W-1:0] issue_a,
  input  logic [DATA_W-1:0] issue_b,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic              abort,
  output logic              stall,
  output logic              busy,
  output logic              md_ctrl_mult,
  output logic              md_ctrl_div,
  output logic [DATA_W-1:0] md_a,
  output logic [DATA_W-1:0] md_b,
  input  logic              md_result_rdy,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              status_we,
  output logic [DATA_W-1:0] status_data
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(MAX_CYCLES - 1);
  localparam logic [DATA_W-1:0] STATUS_MUL_W = DATA_W'(STATUS_MUL);
  localparam logic [DATA_W-1:0] STATUS_DIV_W = DATA_W'(STATUS_DIV);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div_q;
  logic             wb_valid_q;
  logic             status_we_q;

  // Hold the pipeline while the instruction is being captured or the unit
  // runs; a flush releases it in the same cycle.
  assign stall = !abort && ((state == START) || (state == WAIT) ||
                            ((state == IDLE) && issue_valid));
  assign busy  = (state != IDLE);

  // A flush arriving in DONE kills the completing write as well.
  assign wb_valid  = wb_valid_q  && !abort;
  assign status_we = status_we_q && !abort;

  // Sequencer: state, cycle counter, operand latches and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      is_div_q     <= 1'b0;
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      md_a         <= '0;
      md_b         <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      status_we_q  <= 1'b0;
      status_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; the defaults below are
      // overridden later in the same block, giving one-cycle pulses.
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      wb_valid_q   <= 1'b0;
      status_we_q  <= 1'b0;

      if (abort) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (issue_valid) begin
              md_a     <= issue_a;
              md_b     <= issue_b;
              wb_rd    <= issue_rd;
              is_div_q <= issue_is_div;
              if (issue_is_div && (issue_b == '0)) begin
                // Divide-by-zero is reported without starting the unit.
                state       <= DONE;
                wb_data     <= '0;
                status_we_q <= 1'b1;
                status_data <= STATUS_DIV_W;
              end else begin
                state        <= START;
                md_ctrl_mult <= !issue_is_div;
                md_ctrl_div  <= issue_is_div;
              end
            end
          end

          START: begin
            cnt   <= '0;
            state <= WAIT;
          end

          WAIT: begin
            cnt <= cnt + CNT_W'(1);
            if (md_result_rdy) begin
              state       <= DONE;
              wb_data     <= md_result;
              wb_valid_q  <= !md_exception;
              status_we_q <= md_exception;
              status_data <= is_div_q ? STATUS_DIV_W : STATUS_MUL_W;
            end else if (cnt == CNT_LAST) begin
              // Unit never answered: report as an exception with result 0.
              state       <= DONE;
              wb_data     <= '0;
              status_we_q <= 1'b1;
              status_data <= is_div_q ? STATUS_DIV_W : STATUS_MUL_W;
            end
          end

          DONE: begin
            state <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
